// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

    localparam int SS_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: computes x - y - bin, producing the difference
// bit and the borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH), one bit per clock,
// LSB first, through a single full_subtractor cell.
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the signed
// overflow output ovf.
//
// All outputs are registered from the FSM state, so they trail the state by
// one cycle: with start accepted at edge N, busy is high after edges
// N+1..N+WIDTH+1 and done pulses after edge N+WIDTH+1.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic             r_zero;

    logic             w_d;
    logic             w_bout;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep copies.
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    // The single bit-slice; operands are consumed from bit 0 as they shift.
    full_subtractor u_full_subtractor (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // Control FSM, datapath shift registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_busy <= (r_state != ST_IDLE);
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= ST_RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                ST_RUN: begin
                    // Result bits enter at the MSB end; after WIDTH shifts
                    // the first (LSB) result bit sits at position 0.
                    r_diff   <= {w_d, r_diff[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    if (r_cnt == LAST_BIT) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_zero  <= (r_diff == '0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    r_ovf   <= (r_a_msb != r_b_msb) && (r_diff[WIDTH-1] != r_a_msb);
`endif
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign zero   = r_zero;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH = 8). Optional ovf output
// is exercised when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W   = 8;
    localparam int LAT = W + 1;   // edges from accepting edge to done

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; returns #1 after that edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; lat = edge count at which done was seen, 0 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    // Full operation with result, latency, busy-length and pulse-width checks.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input logic ez);
        int lat;
        int bc;
        @(negedge clk);
        launch(av, bv);
        wait_done(lat, bc);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_busy_cycles"}, bc, LAT);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_borrow"}, borrow, eb);
        check({tag, "_zero"}, zero, ez);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_busy_low_after"}, busy, 1'b0);
        $display("[TB] op %s: a=%02h b=%02h -> diff=%02h borrow=%0d zero=%0d lat=%0d",
                 tag, av, bv, diff, borrow, zero, lat);
    endtask

    initial begin
        int lat;
        int bc;
        int n_done;
        logic [W-1:0] seen_diff;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 8'h00);
        check("rst_borrow", borrow, 1'b0);
        check("rst_zero", zero, 1'b0);
        $display("[TB] reset: busy=%0d done=%0d diff=%02h", busy, done, diff);
        rst = 1'b0;

        // Basic differences
        run_op("5m3", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("3m5", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("7m7", 8'h07, 8'h07, 8'h00, 1'b0, 1'b1);
        run_op("0m1", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

        // Results hold in IDLE; operand changes without start have no effect
        a = 8'h55;
        b = 8'h11;
        repeat (3) @(posedge clk);
        #1;
        check("hold_diff", diff, 8'hFF);
        check("hold_borrow", borrow, 1'b1);
        check("hold_zero", zero, 1'b0);
        check("hold_busy", busy, 1'b0);
        $display("[TB] hold: diff=%02h borrow=%0d busy=%0d", diff, borrow, busy);

        // Signed-overflow vectors (diff/borrow checked in every build)
        run_op("80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("ovf_80m01", ovf, 1'b1);
`endif
        run_op("10m01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("ovf_10m01", ovf, 1'b0);
`endif

        // Start re-pulsed during RUN with new operands is ignored
        @(negedge clk);
        launch(8'h9C, 8'h31);
        repeat (2) @(posedge clk);
        #1;
        a     = 8'hFF;
        b     = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'h12;
        b     = 8'h34;
        n_done    = 0;
        seen_diff = '0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                seen_diff = diff;
            end
        end
        check("repulse_done_count", n_done, 1);
        check("repulse_diff", seen_diff, 8'h6B);
        check("repulse_borrow", borrow, 1'b0);
        $display("[TB] repulse: done_pulses=%0d diff=%02h", n_done, seen_diff);

        // Reset at RUN cycle 4 aborts the operation
        @(negedge clk);
        launch(8'h05, 8'h03);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_diff", diff, 8'h00);
        check("abort_borrow", borrow, 1'b0);
        check("abort_zero", zero, 1'b0);
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        $display("[TB] abort: done_pulses=%0d diff=%02h", n_done, diff);
        run_op("post_abort", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

        // Back-to-back: start in the IDLE cycle right after done
        @(negedge clk);
        launch(8'h20, 8'h08);
        wait_done(lat, bc);
        check("b2b1_latency", lat, LAT);
        check("b2b1_diff", diff, 8'h18);
        launch(8'h08, 8'h20);
        wait_done(lat, bc);
        check("b2b2_latency", lat, LAT);
        check("b2b2_diff", diff, 8'hE8);
        check("b2b2_borrow", borrow, 1'b1);
        $display("[TB] back-to-back: diff=%02h borrow=%0d lat=%0d", diff, borrow, lat);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
